// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Types and constants shared by the RV32I core front end.
//                XLEN        - architectural register / address width
//                NOP_INSTR   - canonical NOP (ADDI x0,x0,0), also used to fill
//                              the instruction memory
//                fetch_entry_t - one prefetch queue entry {pc, instr}
//                align_word  - clears the two low address bits
//  Revision    : 1.0  initial release
// ============================================================================
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage : core_pkg
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Fetch-to-decode valid/ready handshake.
//                out_valid  - head of the prefetch queue holds an instruction
//                out_ready  - decode takes the head this cycle
//                out_instr  - head instruction word
//                out_pc     - PC of the head instruction
//                master : fetch side, slave : decode side
//  Revision    : 1.0  initial release
// ============================================================================
interface fetch_unit_if;

    logic                       out_valid;
    logic                       out_ready;
    logic [core_pkg::XLEN-1:0]  out_instr;
    logic [core_pkg::XLEN-1:0]  out_pc;

    modport master (
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready
    );

endinterface : fetch_unit_if
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Registered prefetch queue of fetch_entry_t words.
//                clk, rst_n  - clock, asynchronous active-low reset
//                push, push_data - write an entry at the tail
//                pop         - retire the head entry (ignored when empty)
//                flush       - empty the queue; overrides push and pop
//                head        - current head entry (undefined when empty)
//                count       - number of valid entries, 0..DEPTH
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH = 2
) (
    input  wire                          clk,
    input  wire                          rst_n,
    input  wire                          push,
    input  core_pkg::fetch_entry_t       push_data,
    input  wire                          pop,
    input  wire                          flush,
    output core_pkg::fetch_entry_t       head,
    output logic [$clog2(DEPTH):0]       count
);
    import core_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t       r_mem [DEPTH];
    logic [AW-1:0]      r_rd_ptr;
    logic [AW-1:0]      r_wr_ptr;
    logic [CW-1:0]      r_count;

    logic               w_do_push;
    logic               w_do_pop;

    // Flush wins over both ports: anything offered in a flush cycle is dropped.
    assign w_do_push = push & ~flush;
    assign w_do_pop  = pop & ~flush & (r_count != '0);

    // Storage carries no reset; entries are only visible through count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : RV32I fetch front end. Owns the fetch PC, addresses the
//                word-aligned instruction memory, queues returned words with
//                their PC and hands them to decode over valid/ready.
//                clk, rst_n      - clock, asynchronous active-low reset
//                fetch_en        - allow new fetches (draining continues)
//                imem_pc         - instruction memory address (= fetch PC)
//                imem_instr      - same-cycle read data for imem_pc
//                dec             - decode handshake (master side)
//                redirect_valid  - load redirect_pc and flush the queue
//                redirect_pc     - new fetch target
//                misalign_err    - one-cycle pulse after a misaligned redirect
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter logic [core_pkg::XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int                        DEPTH     = 2,
    parameter logic [core_pkg::XLEN-1:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
    input  wire                          clk,
    input  wire                          rst_n,
    input  wire                          fetch_en,
    output logic [core_pkg::XLEN-1:0]    imem_pc,
    input  wire  [core_pkg::XLEN-1:0]    imem_instr,
    fetch_unit_if.master                 dec,
    input  wire                          redirect_valid,
    input  wire  [core_pkg::XLEN-1:0]    redirect_pc,
    output logic                         misalign_err
);
    import core_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]    r_pc;
    logic               r_misalign;

    logic               w_pop;
    logic               w_push;
    logic               w_not_full;
    logic               w_valid;
    logic [CW-1:0]      w_count;
    fetch_entry_t       w_push_entry;
    fetch_entry_t       w_head;

    assign w_valid    = (w_count != '0);
    assign w_not_full = (w_count < CW'(DEPTH));
    assign w_pop      = w_valid & dec.out_ready;
    // A full queue still accepts a word when the head leaves in the same cycle.
    assign w_push     = fetch_en & ~redirect_valid & (w_not_full | w_pop);

    always_comb begin
        w_push_entry       = '0;
        w_push_entry.pc    = r_pc;
        w_push_entry.instr = imem_instr;
    end

    fetch_fifo #(
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (w_push),
        .push_data  (w_push_entry),
        .pop        (w_pop),
        .flush      (redirect_valid),
        .head       (w_head),
        .count      (w_count)
    );

    // Redirect has priority; the target is force-aligned even when misaligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= redirect_valid & (redirect_pc[1:0] != 2'b00);
            if (redirect_valid) begin
                r_pc <= align_word(redirect_pc);
            end else if (w_push) begin
                r_pc <= r_pc + XLEN'(4);
            end
        end
    end

    assign imem_pc       = r_pc;
    assign misalign_err  = r_misalign;

    // Empty queue drives known values so decode never sees stale storage.
    assign dec.out_valid = w_valid;
    assign dec.out_instr = w_valid ? w_head.instr : NOP_INSTR;
    assign dec.out_pc    = w_valid ? w_head.pc    : '0;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. A queue-based model of
//                the fetch rules is compared against the DUT every cycle, and
//                directed scenarios pin the model with literal values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;
    import core_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misalign_err;

    fetch_unit_if dec_if ();

    fetch_unit #(
        .RESET_PC       (32'h0000_0000),
        .DEPTH          (DEPTH),
        .NOP_INSTR      (NOP)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .dec            (dec_if.master),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: two known words, a PC-derived pattern elsewhere.
    function automatic logic [31:0] imem_fn(input logic [31:0] pc);
        if (pc == 32'h0000_0000) return 32'h0000_0093;
        if (pc == 32'h0000_0004) return 32'h0010_0113;
        return pc ^ 32'hC0DE_0003;
    endfunction

    assign imem_instr = imem_fn(imem_pc);

    int total = 0;
    int bad   = 0;
    bit run_cmp = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    fetch_entry_t m_q[$];
    logic [31:0]  m_pc  = 32'h0;
    logic         m_mis = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_pc  = 32'h0;
            m_mis = 1'b0;
        end else begin
            m_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (redirect_valid) begin
                m_q.delete();
                m_pc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (m_q.size() > 0 && dec_if.out_ready) void'(m_q.pop_front());
                if (fetch_en && m_q.size() < DEPTH) begin
                    m_q.push_back('{pc: m_pc, instr: imem_fn(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (run_cmp) begin
                chk("cyc_valid", {31'b0, dec_if.out_valid}, {31'b0, m_q.size() > 0});
                chk("cyc_pc", dec_if.out_pc, (m_q.size() > 0) ? m_q[0].pc : 32'h0);
                chk("cyc_instr", dec_if.out_instr, (m_q.size() > 0) ? m_q[0].instr : NOP);
                chk("cyc_imem_pc", imem_pc, m_pc);
                chk("cyc_misalign", {31'b0, misalign_err}, {31'b0, m_mis});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n            = 1'b0;
        fetch_en         = 1'b1;
        dec_if.out_ready = 1'b1;
        redirect_valid   = 1'b0;
        redirect_pc      = 32'h0;
        step();
        step();
        run_cmp = 1'b1;
        chk("rst_valid", {31'b0, dec_if.out_valid}, 32'd0);
        chk("rst_instr", dec_if.out_instr, NOP);
        chk("rst_pc", dec_if.out_pc, 32'h0);
        chk("rst_imem_pc", imem_pc, 32'h0);
        chk("rst_misalign", {31'b0, misalign_err}, 32'd0);

        // first fetches with decode always ready
        rst_n = 1'b1;
        step();
        chk("t1_valid", {31'b0, dec_if.out_valid}, 32'd1);
        chk("t1_pc0", dec_if.out_pc, 32'h0);
        chk("t1_instr0", dec_if.out_instr, 32'h0000_0093);
        step();
        chk("t1_pc4", dec_if.out_pc, 32'h4);
        chk("t1_instr4", dec_if.out_instr, 32'h0010_0113);

        // back-pressure fills the queue, then drains in order
        rst_n = 1'b0;
        dec_if.out_ready = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (5) step();
        chk("t2_valid", {31'b0, dec_if.out_valid}, 32'd1);
        chk("t2_head_pc", dec_if.out_pc, 32'h0);
        chk("t2_imem_pc", imem_pc, 32'h8);
        dec_if.out_ready = 1'b1;
        step();
        chk("t2_pc4", dec_if.out_pc, 32'h4);
        step();
        chk("t2_pc8", dec_if.out_pc, 32'h8);

        // redirect while full
        dec_if.out_ready = 1'b0;
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        step();
        redirect_valid = 1'b0;
        chk("t3_valid", {31'b0, dec_if.out_valid}, 32'd0);
        chk("t3_misalign", {31'b0, misalign_err}, 32'd0);
        chk("t3_imem_pc", imem_pc, 32'h40);
        step();
        chk("t3_pc40", dec_if.out_pc, 32'h40);
        chk("t3_instr40", dec_if.out_instr, 32'hC0DE_0043);
        dec_if.out_ready = 1'b1;

        // misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0046;
        step();
        redirect_valid = 1'b0;
        chk("t4_imem_pc", imem_pc, 32'h44);
        chk("t4_misalign_hi", {31'b0, misalign_err}, 32'd1);
        step();
        chk("t4_misalign_lo", {31'b0, misalign_err}, 32'd0);
        chk("t4_pc44", dec_if.out_pc, 32'h44);

        // address wrap
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        chk("t5_valid", {31'b0, dec_if.out_valid}, 32'd0);
        step();
        chk("t5_pc_f8", dec_if.out_pc, 32'hFFFF_FFF8);
        step();
        chk("t5_pc_fc", dec_if.out_pc, 32'hFFFF_FFFC);
        step();
        chk("t5_pc_0", dec_if.out_pc, 32'h0);

        // fetch disabled: drain two entries, PC frozen
        dec_if.out_ready = 1'b0;
        step();
        step();
        chk("t6_full_imem_pc", imem_pc, 32'h8);
        fetch_en         = 1'b0;
        dec_if.out_ready = 1'b1;
        step();
        chk("t6_pc4", dec_if.out_pc, 32'h4);
        chk("t6_hold_pc", imem_pc, 32'h8);
        step();
        chk("t6_empty_valid", {31'b0, dec_if.out_valid}, 32'd0);
        chk("t6_empty_instr", dec_if.out_instr, NOP);
        chk("t6_empty_pc", dec_if.out_pc, 32'h0);
        chk("t6_frozen_pc", imem_pc, 32'h8);

        // reset asserted mid-drain
        fetch_en         = 1'b1;
        dec_if.out_ready = 1'b0;
        step();
        step();
        fetch_en         = 1'b0;
        dec_if.out_ready = 1'b1;
        step();
        chk("t7_pc12", dec_if.out_pc, 32'hC);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_valid", {31'b0, dec_if.out_valid}, 32'd0);
        chk("t7_rst_instr", dec_if.out_instr, NOP);
        chk("t7_rst_pc", dec_if.out_pc, 32'h0);
        chk("t7_rst_imem_pc", imem_pc, 32'h0);
        step();
        rst_n    = 1'b1;
        fetch_en = 1'b1;
        step();
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Front end of the multicycle RV32I core, directly upstream of the word-aligned instruction memory.
- Owns the fetch PC, drives the memory address, and captures each returned word with its PC into a small prefetch queue.
- Presents instructions to decode over a valid/ready handshake.
- Accepts redirects (branch/jump/trap) from the execute/control FSM, which flush the queue.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- DEPTH, 2, prefetch queue entries (power of two, ≥2).
- NOP_INSTR, 32'h0000_0013, value driven on out_instr when the queue is empty or in reset (ADDI x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_en  in  1  allow new fetches; 0 holds pc_q and blocks pushes, while draining continues.
- imem_pc  out  32  address to instruction memory; equals pc_q combinationally.
- imem_instr  in  32  combinational read data for imem_pc (same cycle).
- out_valid  out  1  queue head is a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  32  head instruction word; NOP_INSTR when empty.
- out_pc  out  32  PC of the head instruction; 0 when empty.
- redirect_valid  in  1  replace fetch PC and flush the queue.
- redirect_pc  in  32  new fetch target.
- misalign_err  out  1  one-cycle pulse: redirect_pc[1:0] was nonzero.

Behaviour:
- Reset (async, rst_n=0):
  - pc_q=RESET_PC, count=0, out_valid=0, out_instr=NOP_INSTR, out_pc=0, misalign_err=0.
  - Queue contents are don't-care.
- pop = out_valid & out_ready.
- push = fetch_en & ~redirect_valid & (count<DEPTH | pop).
  - A push when full is legal only together with a pop (same-cycle push+pop keeps count).
- On push:
  - Entry {pc_q, imem_instr} is written at the tail.
  - pc_q <= pc_q+4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- count update: push&~pop +1; pop&~push −1; both or neither unchanged.
- Queue is registered: a word pushed in cycle N is visible at the head in cycle N+1 at the earliest.
  - Minimum fetch-to-decode latency: 1 cycle.
  - Reset release → first out_valid on the 2nd rising edge after rst_n rises (1st edge pushes).
- Head ordering is strict FIFO; out_instr/out_pc are stable while out_valid=1 & out_ready=0.
- Redirect (highest priority):
  - redirect_valid=1 in cycle N: queue flushed (count<=0); any pop or push in N is discarded.
  - pc_q <= {redirect_pc[31:2],2'b00}.
  - out_valid=0 in N+1; first new-target instruction valid in N+2 if fetch_en=1.
- misalign_err:
  - Registered; set to 1 for exactly cycle N+1 when redirect_valid & redirect_pc[1:0]≠0 in N; otherwise 0.
  - The aligned PC is still used.
- fetch_en=0:
  - pc_q frozen, no push; head continues to drain.
  - Redirect still applies.
- Reset mid-operation: immediate return to reset values; in-flight entries are lost.
- No X on outputs after reset: empty queue drives NOP_INSTR/0.

Decomposition:
- Shared package core_pkg:
  - XLEN=32.
  - NOP_INSTR constant (shared with instruction memory init).
  - typedef fetch_entry_t {logic [31:0] pc; logic [31:0] instr;}.
- One natural sub-module: fetch_fifo.
  - Parameterised DEPTH, entry type fetch_entry_t.
  - Ports: push/pop/flush, count; pointer wrap via power-of-two index.
  - fetch_unit keeps the PC register, the push/redirect logic and misalign_err.

Test Plan:
- Reset, imem returns 32'h0000_0093 at pc 0 and 32'h0010_0113 at pc 4, out_ready=1 → out_valid first high 2 edges after release with out_pc=0 / out_instr=32'h0000_0093, next cycle out_pc=4 / out_instr=32'h0010_0113.
- out_ready=0 for 5 cycles from reset → exactly DEPTH=2 entries (pc 0, 4), pc_q/imem_pc holds 8, head stable; raise out_ready → pc 0, 4, 8 in consecutive cycles, no gaps or duplicates.
- Redirect to 32'h0000_0040 while queue full → next cycle out_valid=0, misalign_err=0; following cycle out_pc=32'h40; entries for pc 8, 12 never appear.
- Redirect to 32'h0000_0046 → imem_pc=32'h44, misalign_err high exactly one cycle, then out_pc=32'h44.
- Redirect to 32'hFFFF_FFF8 with continuous ready → out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- fetch_en=0 with 2 queued, out_ready=1 → 2 pops then out_valid=0, out_instr=NOP_INSTR, imem_pc constant; assert rst_n=0 mid-drain → outputs at reset values the same cycle.
